imem_fetch_resp: RTL
====================

// Module: imem_fetch_resp
// PURPOSE
// - Instruction-memory responder on the far end of the program counter's address output.
// - Accepts the fetch address (PC value) via valid/ready and returns the stored instruction one cycle later via valid/ready.
// - Loads the program through a write port while in LOAD state, then serves fetches in RUN.
// - Discards in-flight fetches on a branch flush.
// PARAMETERS
// - AW     8    fetch/load address width (matches 8-bit PC)
// - IW     16   instruction word width
// - DEPTH  256  implemented words, 1..2**AW
// PORTS
// - clk        in   1   single clock, rising edge
// - reset      in   1   asynchronous, active-low reset (0 = reset)
// - req_addr   in   AW  fetch address from PC
// - req_valid  in   1   fetch request present
// - req_ready  out  1   responder accepts request this cycle
// - flush      in   1   branch taken (PC control): drop pending/in-flight instruction
// - instr      out  IW  fetched instruction
// - instr_valid out 1   instr holds a valid response
// - instr_ready in  1   consumer takes instr this cycle
// - ld_we      in   1   program-load write strobe (LOAD state only)
// - ld_addr    in   AW  program-load address
// - ld_data    in   IW  program-load data
// - ld_done    in   1   end of program load, move to RUN
// - run        out  1   1 when in RUN state
// - oor        out  1   sticky: a fetch hit addr >= DEPTH
// - par_err    out  1   sticky parity error (see CONFIGURATION)
// BEHAVIOUR
// - Reset (reset=0, async): state=LOAD, instr_valid=0, instr=0, run=0, oor=0, par_err=0.
//   Memory contents are NOT cleared; reset mid-fetch discards the fetch.
// - FSM: LOAD --ld_done--> RUN; RUN is left only by reset.
// - LOAD: ld_we writes mem[ld_addr]=ld_data at the clock edge. ld_we and ld_done in the same cycle: write done, then RUN.
//   req_ready=0. ld_addr>=DEPTH: write dropped.
// - RUN: ld_we/ld_done ignored.
//   req_ready = run & ~flush & (~instr_valid | instr_ready).
// - Handshake: a request is accepted when req_valid & req_ready.
//   Next cycle: instr=mem[req_addr], instr_valid=1. Latency is exactly 1 cycle.
//   Back-to-back accepts give one instruction per cycle.
// - Stall: while instr_valid & ~instr_ready, instr and instr_valid hold and req_ready=0.
// - Response taken (instr_ready=1) with no new accept: instr_valid clears next cycle; instr holds its value.
// - flush=1: instr_valid=0 next cycle regardless of instr_ready, and no request is accepted that cycle.
//   flush wins over every other event.
// - Out of range: accepted req_addr >= DEPTH returns instr=0 (NOP) and sets oor.
//   There is no address wrap; the PC owns wrap-around at 2**AW.
// CONFIGURATION
// - IMEM_PARITY_EN defined:
//   - each word stores an extra even-parity bit, computed on load;
//   - on each accepted fetch the parity is rechecked; a mismatch sets sticky par_err with the response;
//   - instr is still delivered.
// - Undefined: no parity storage; par_err tied 0.
// STRUCTURE
// - Package imem_pkg: AW/IW defaults, state enum {ST_LOAD, ST_RUN}, NOP word constant, parity function.
// - Sub-module imem_array: DEPTH x IW (+1 parity) storage, one sync write port, one registered read port.
// - Top level holds the FSM, handshake/stall/flush control and the sticky flags.
// TESTING
// - Load: load mem[0..3]=16'h1111,2222,3333,4444, pulse ld_done.
//   Expect run=1 next cycle; stream addr 0..3 with instr_ready=1; instr 1111..4444, one per cycle, each 1 cycle after accept.
// - Stall: hold instr_ready=0 after the fetch of addr 1.
//   Expect instr=16'h2222 held, req_ready=0 for 3 cycles; release, then next fetch resumes.
// - Flush: accept addr 2, assert flush the next cycle.
//   Expect instr_valid=0 after flush and no accept during flush; fetch addr 0 then returns 16'h1111.
// - Load plus done: ld_we and ld_done together at addr 5 with 16'hABCD.
//   Expect a fetch of 5 to return ABCD; later ld_we in RUN to addr 5 leaves ABCD unchanged.
// - Out of range / reset: DEPTH=16, fetch addr 8'h20 -> instr=0, oor=1.
//   Assert reset mid-stall -> instr_valid=0, run=0, oor=0 at once; memory still holds 16'h1111 at 0.
// - Parity (IMEM_PARITY_EN): force a bit flip in stored word 3, fetch addr 3 -> instr returned, par_err=1 and sticky.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, defaults and parity helper for the instruction memory responder
package imem_pkg;

  localparam int AW_DEF = 8;
  localparam int IW_DEF = 16;

  // Word returned for fetches outside the implemented depth
  localparam logic [IW_DEF-1:0] NOP_WORD = '0;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Even-parity bit: storing it next to the word makes the total count of ones even
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - DEPTH x IW storage, one sync write port, one registered read port (parity bit when IMEM_PARITY_EN)
module imem_array
  import imem_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int IW    = IW_DEF,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] rd_data
`ifdef IMEM_PARITY_EN
  ,
  output logic          rd_perr
`endif
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

`ifdef IMEM_PARITY_EN
  localparam int SW = IW + 1;
`else
  localparam int SW = IW;
`endif

  logic [SW-1:0] mem [DEPTH];

  logic            wr_in_range;
  logic            rd_in_range;
  logic [IDXW-1:0] wr_idx;
  logic [IDXW-1:0] rd_idx;
  logic [SW-1:0]   rd_word;
  logic [SW-1:0]   wr_word;
  logic [IW-1:0]   rd_data_q;
  logic [IW-1:0]   rd_data_d;

  // Range decode: addresses at or above DEPTH fall outside storage and do not wrap
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign wr_idx      = wr_addr[IDXW-1:0];
  assign rd_idx      = rd_addr[IDXW-1:0];
  assign rd_word     = mem[rd_idx];

`ifdef IMEM_PARITY_EN
  assign wr_word = {even_parity(64'(wr_data)), wr_data};
`else
  assign wr_word = wr_data;
`endif

  // Storage is deliberately not reset so a reset keeps the loaded program
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_idx] <= wr_word;
    end
  end

`ifdef IMEM_PARITY_EN
  logic rd_perr_q;
  logic rd_perr_d;

  // Read data updates only on a read; parity mismatch is a one-cycle pulse beside the new data
  always_comb begin
    rd_data_d = rd_data_q;
    rd_perr_d = 1'b0;
    if (rd_en) begin
      if (rd_in_range) begin
        rd_data_d = rd_word[IW-1:0];
        rd_perr_d = (even_parity(64'(rd_word[IW-1:0])) != rd_word[IW]);
      end else begin
        rd_data_d = IW'(NOP_WORD);
      end
    end
  end

  // Read register and parity pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
      rd_perr_q <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_perr_q <= rd_perr_d;
    end
  end

  assign rd_perr = rd_perr_q;
`else
  // Read data updates only on a read and otherwise holds for stalls
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (rd_in_range) begin
        rd_data_d = rd_word[IW-1:0];
      end else begin
        rd_data_d = IW'(NOP_WORD);
      end
    end
  end

  // Read register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end
`endif

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_fetch_resp.sv
// rtl/imem_fetch_resp.sv - instruction memory responder: LOAD/RUN FSM, fetch handshake, flush, sticky flags (IMEM_PARITY_EN adds parity)
module imem_fetch_resp
  import imem_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int IW    = IW_DEF,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] req_addr,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          flush,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [IW-1:0] ld_data,
  input  logic          ld_done,
  output logic          run,
  output logic          oor,
  output logic          par_err
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  state_t state_q;
  state_t state_d;
  logic   instr_valid_q;
  logic   instr_valid_d;
  logic   oor_q;
  logic   oor_d;
  logic   accept;
  logic   wr_en;
  logic   req_oor;

  assign run       = (state_q == ST_RUN);
  // A new request fits when the output slot is empty or is being drained this cycle
  assign req_ready = run & ~flush & (~instr_valid_q | instr_ready);
  assign accept    = req_valid & req_ready;
  assign wr_en     = ld_we & (state_q == ST_LOAD);
  assign req_oor   = ({1'b0, req_addr} >= DEPTH_W);

  // Next state: LOAD leaves on ld_done, RUN only exits through reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (ld_done) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_LOAD;
    endcase
  end

  // Response-valid tracking; flush beats accept, accept beats drain
  always_comb begin
    instr_valid_d = instr_valid_q;
    if (flush) begin
      instr_valid_d = 1'b0;
    end else if (accept) begin
      instr_valid_d = 1'b1;
    end else if (instr_ready) begin
      instr_valid_d = 1'b0;
    end
  end

  // Out-of-range flag rises together with the NOP response
  always_comb begin
    oor_d = oor_q | (accept & req_oor);
  end

  // Control and sticky-flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_LOAD;
      instr_valid_q <= 1'b0;
      oor_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_valid_q <= instr_valid_d;
      oor_q         <= oor_d;
    end
  end

  assign instr_valid = instr_valid_q;
  assign oor         = oor_q;

`ifdef IMEM_PARITY_EN
  logic rd_perr;
  logic par_err_q;
  logic par_err_d;

  imem_array #(
    .AW    (AW),
    .IW    (IW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_en   (accept),
    .rd_addr (req_addr),
    .rd_data (instr),
    .rd_perr (rd_perr)
  );

  // Accumulate parity errors reported with each fresh response
  always_comb begin
    par_err_d = par_err_q | rd_perr;
  end

  // Sticky parity error register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  // The flag shows in the same cycle as the faulty response and stays set
  assign par_err = par_err_q | rd_perr;
`else
  imem_array #(
    .AW    (AW),
    .IW    (IW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_en   (accept),
    .rd_addr (req_addr),
    .rd_data (instr)
  );

  assign par_err = 1'b0;
`endif

endmodule
